branch_target_buffer: RTL and testbench



---
 rtl/branch_target_buffer_if.sv | 17 +
 rtl/branch_target_buffer.sv | 71 +++++++
 tb/tb_branch_target_buffer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: fetch/resolve bus between PC logic and the BTB; stat signals exist only with BTB_STATS_EN
interface branch_target_buffer_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] fetch_pc, pred_target, upd_pc, upd_target, upd_pred_target, redirect_pc;
  logic pred_hit, pred_taken, upd_valid, upd_taken, upd_pred_taken, flush_all, mispredict;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
  modport master(output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush_all,
                 input pred_hit, pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_mispredicts);
  modport slave(input fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush_all,
                output pred_hit, pred_taken, pred_target, mispredict, redirect_pc, stat_branches, stat_mispredicts);
`else
  modport master(output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush_all,
                 input pred_hit, pred_taken, pred_target, mispredict, redirect_pc);
  modport slave(input fetch_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush_all,
                output pred_hit, pred_taken, pred_target, mispredict, redirect_pc);
`endif
endinterface

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters; optional 32-bit stats via BTB_STATS_EN
module branch_target_buffer #(
  parameter int ADDR_W = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W = 2
) (
  input logic clk,
  input logic rst,
  branch_target_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [ADDR_W-1:0] target [ENTRIES];
  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic [CTR_W-1:0] u_ctr, u_ctr_next;
  logic u_hit, unused_low_bits;
  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_low_bits = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};
  assign bus.pred_hit = valid[f_idx] && tag[f_idx] == f_tag;
  assign bus.pred_taken = bus.pred_hit && ctr[f_idx][CTR_W-1];
  assign bus.pred_target = bus.pred_taken ? target[f_idx] : bus.fetch_pc + ADDR_W'(4);
  assign bus.mispredict = bus.upd_valid && (bus.upd_taken != bus.upd_pred_taken ||
                          (bus.upd_taken && bus.upd_pred_taken && bus.upd_target != bus.upd_pred_target));
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + ADDR_W'(4);
  assign u_hit = valid[u_idx] && tag[u_idx] == u_tag;
  assign u_ctr = ctr[u_idx];
  assign u_ctr_next = bus.upd_taken ? (u_ctr == CTR_MAX ? u_ctr : u_ctr + 1'b1)
                                    : (u_ctr == '0 ? u_ctr : u_ctr - 1'b1);
  // valid/ctr: async clear, flush drops valid only and wins over an update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= '0;
    end else if (bus.flush_all) begin
      valid <= '0;
    end else if (bus.upd_valid && u_hit) begin
      ctr[u_idx] <= u_ctr_next;
    end else if (bus.upd_valid && bus.upd_taken) begin
      valid[u_idx] <= 1'b1;
      ctr[u_idx] <= CTR_WEAK;
    end
  end
  // tag/target need no reset; a taken resolve rewrites them whether hit or allocate
  always_ff @(posedge clk) begin
    if (!bus.flush_all && bus.upd_valid && bus.upd_taken) begin
      tag[u_idx] <= u_tag;
      target[u_idx] <= bus.upd_target;
    end
  end
`ifdef BTB_STATS_EN
  // saturating resolve/mispredict counters, immune to flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.stat_branches <= '0;
      bus.stat_mispredicts <= '0;
    end else if (bus.upd_valid && !bus.flush_all) begin
      if (bus.stat_branches != '1) bus.stat_branches <= bus.stat_branches + 1;
      if (bus.mispredict && bus.stat_mispredicts != '1) bus.stat_mispredicts <= bus.stat_mispredicts + 1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed plan scenarios plus random traffic against an index/tag array model
module tb_branch_target_buffer;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  bit m_valid [16];
  int unsigned m_tag [16];
  logic [31:0] m_target [16];
  int m_ctr [16];
  longint m_br = 0, m_mp = 0;
  branch_target_buffer_if #(.ADDR_W(32)) bus();
  branch_target_buffer #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i] = 0;
    end
    m_br = 0;
    m_mp = 0;
  endfunction
  function automatic void look(input logic [31:0] pc, output bit h, output bit t, output logic [31:0] tg);
    int i = int'(pc[5:2]);
    h = m_valid[i] && m_tag[i] == int'(pc[31:6]);
    t = h && m_ctr[i] >= 2;
    tg = t ? m_target[i] : pc + 4;
  endfunction
  task automatic cycle(input logic [31:0] f, input bit uv, input logic [31:0] up, input bit ut,
                       input logic [31:0] utg, input bit upt, input logic [31:0] uptg, input bit fl);
    bit h, t, em;
    logic [31:0] tg;
    int i;
    @(negedge clk);
    bus.fetch_pc = f; bus.upd_valid = uv; bus.upd_pc = up; bus.upd_taken = ut;
    bus.upd_target = utg; bus.upd_pred_taken = upt; bus.upd_pred_target = uptg; bus.flush_all = fl;
    #2;
    look(f, h, t, tg);
    chk("pred_hit", bus.pred_hit, h);
    chk("pred_taken", bus.pred_taken, t);
    chk("pred_target", bus.pred_target, tg);
    em = uv && (ut != upt || (ut && upt && utg != uptg));
    chk("mispredict", bus.mispredict, em);
    if (uv) chk("redirect_pc", bus.redirect_pc, ut ? utg : up + 4);
`ifdef BTB_STATS_EN
    chk("stat_branches", bus.stat_branches, m_br);
    chk("stat_mispredicts", bus.stat_mispredicts, m_mp);
`endif
    @(posedge clk);
    i = int'(up[5:2]);
    if (fl) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (uv) begin
      m_br++;
      if (em) m_mp++;
      if (m_valid[i] && m_tag[i] == int'(up[31:6])) begin
        m_ctr[i] = ut ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
        if (ut) m_target[i] = utg;
      end else if (ut) begin
        m_valid[i] = 1; m_tag[i] = int'(up[31:6]); m_target[i] = utg; m_ctr[i] = 2;
      end
    end
  endtask
  task automatic upd(input logic [31:0] f, input logic [31:0] up, input bit ut, input logic [31:0] utg);
    bit h, t;
    logic [31:0] tg;
    look(up, h, t, tg);
    cycle(f, 1, up, ut, utg, t, tg, 0);
  endtask
  task automatic idle(input logic [31:0] f);
    cycle(f, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bit h, t;
    logic [31:0] tg, pc;
    bus.fetch_pc = 32'h40; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_taken = 0;
    bus.upd_target = 0; bus.upd_pred_taken = 0; bus.upd_pred_target = 0; bus.flush_all = 0;
    model_reset();
    #1;
    chk("reset_hit", bus.pred_hit, 0);
    chk("reset_target", bus.pred_target, 32'h44);
    @(negedge clk);
    rst = 0;
    upd(32'h40, 32'h40, 0, 32'h0);
    idle(32'h40);
    chk("no_nt_alloc", bus.pred_hit, 0);
    cycle(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
    chk("cold_mispredict", bus.mispredict, 1);
    chk("cold_redirect", bus.redirect_pc, 32'h100);
    idle(32'h40);
    chk("cold_target", bus.pred_target, 32'h100);
    repeat (3) upd(32'h40, 32'h40, 0, 32'h0);
    idle(32'h40);
    chk("trained_nt", bus.pred_target, 32'h44);
    repeat (4) upd(32'h40, 32'h40, 1, 32'h100);
    upd(32'h40, 32'h40, 0, 32'h0);
    idle(32'h40);
    chk("sat_taken", bus.pred_taken, 1);
    upd(32'h80, 32'h80, 1, 32'h200);
    idle(32'h40);
    chk("alias_miss", bus.pred_hit, 0);
    idle(32'h80);
    chk("alias_target", bus.pred_target, 32'h200);
    upd(32'h40, 32'h40, 1, 32'h100);
    cycle(32'h40, 1, 32'h40, 1, 32'h300, 0, 32'h44, 0);
    chk("rw_old", bus.pred_target, 32'h100);
    idle(32'h40);
    chk("rw_new", bus.pred_target, 32'h300);
    cycle(32'h40, 1, 32'h40, 1, 32'h300, 1, 32'h100, 0);
    chk("wrong_target", bus.mispredict, 1);
    upd(32'h88, 32'h88, 1, 32'h500);
    cycle(32'h40, 1, 32'h4c, 1, 32'h600, 0, 32'h50, 1);
    for (int k = 0; k < 16; k++) idle(32'h40 + 32'(k * 4));
    chk("flush_hit", bus.pred_hit, 0);
    upd(32'h40, 32'h40, 1, 32'h700);
    @(negedge clk);
    bus.upd_valid = 0; bus.flush_all = 0; bus.fetch_pc = 32'h40;
    #1;
    chk("pre_rst_hit", bus.pred_hit, 1);
    rst = 1;
    #1;
    chk("rst_hit", bus.pred_hit, 0);
    chk("rst_target", bus.pred_target, 32'h44);
`ifdef BTB_STATS_EN
    chk("rst_stat_br", bus.stat_branches, 0);
    chk("rst_stat_mp", bus.stat_mispredicts, 0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int n = 0; n < 500; n++) begin
      pc = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      look(pc, h, t, tg);
      if ($urandom_range(0, 3) == 0) begin
        t = 1'($urandom);
        tg = $urandom & ~32'h3;
      end
      cycle(32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)),
            $urandom_range(0, 3) != 0, pc, 1'($urandom), 32'($urandom_range(0, 7) << 4),
            t, tg, $urandom_range(0, 31) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
